// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencing controller.
// Latency: n/a (constants and pure decode helpers only).
// Backpressure: n/a.
package mips_ctrl_pkg;

    // Opcodes (IR[31:26]) and the jr function code (IR[5:0])
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_SLTIU = 6'd11;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_LBU   = 6'd36;
    localparam logic [5:0] OP_LHU   = 6'd37;
    localparam logic [5:0] OP_SB    = 6'd40;
    localparam logic [5:0] OP_SH    = 6'd41;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    // State encodings
    localparam int         ST_W        = 4;
    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEM_ADDR = 4'd2;
    localparam logic [3:0] ST_MEM_RD   = 4'd3;
    localparam logic [3:0] ST_MEM_WB   = 4'd4;
    localparam logic [3:0] ST_MEM_WR   = 4'd5;
    localparam logic [3:0] ST_R_EXEC   = 4'd6;
    localparam logic [3:0] ST_R_WB     = 4'd7;
    localparam logic [3:0] ST_I_EXEC   = 4'd8;
    localparam logic [3:0] ST_I_WB     = 4'd9;
    localparam logic [3:0] ST_BRANCH   = 4'd10;
    localparam logic [3:0] ST_JUMP     = 4'd11;
    localparam logic [3:0] ST_JR       = 4'd12;
    localparam logic [3:0] ST_EXCEPT   = 4'd13;

    // Datapath select codes
    localparam logic [1:0] ALU_ADD     = 2'b00;
    localparam logic [1:0] ALU_SUB     = 2'b01;
    localparam logic [1:0] ALU_RFUNCT  = 2'b10;
    localparam logic [1:0] ALU_IOP     = 2'b11;
    localparam logic [1:0] PCS_ALU     = 2'b00;
    localparam logic [1:0] PCS_ALUOUT  = 2'b01;
    localparam logic [1:0] PCS_JUMP    = 2'b10;
    localparam logic [1:0] PCS_REG_A   = 2'b11;
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;
    localparam logic [1:0] RDST_RT     = 2'b00;
    localparam logic [1:0] RDST_RD     = 2'b01;
    localparam logic [1:0] RDST_RA     = 2'b10;
    localparam logic [1:0] M2R_ALUOUT  = 2'b00;
    localparam logic [1:0] M2R_MDR     = 2'b01;
    localparam logic [1:0] M2R_PC      = 2'b10;
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SW, OP_SB, OP_SH};
    endfunction

    function automatic logic is_itype(input logic [5:0] op);
        return op inside {OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI};
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive cycles a memory wait state spends without mem_ready.
// Latency: timeout is combinational in the MEM_TIMEOUT-th wait cycle.
// Backpressure: none; count clears whenever the wait ends or is not active.
// Ports: clk, reset (sync, active-high), active (in a wait state), mem_ready, timeout.
module mc_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // count_q holds the number of earlier wait cycles, so the current one is
    // the MEM_TIMEOUT-th when count_q reaches MEM_TIMEOUT-1. The FSM leaves a
    // wait state only on mem_ready or timeout, both of which clear the count,
    // so every wait state is entered with a zero count.
    always_comb begin
        timeout = active && !mem_ready && (count_q == CNT_W'(MEM_TIMEOUT - 1));
        count_d = '0;
        if (active && !mem_ready && !timeout) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Sequencing controller for the multi-cycle MIPS datapath (Moore outputs per state).
// Latency: one state per cycle; FETCH/MEM_RD/MEM_WR advance in the cycle mem_ready is seen.
// Backpressure: holds in memory states until mem_ready (bounded only with MC_CTRL_EXC_EN).
// Ports: clk, reset (sync active-high), opcode/funct from IR, mem_ready; datapath
// enables/selects, epc_write/cause (exceptions), state_o (debug).
// Build option: define MC_CTRL_EXC_EN to enable illegal-opcode and memory-timeout exceptions.
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int STATE_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               branch_ne,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic [1:0]         mem_to_reg,
    output logic [1:0]         reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               epc_write,
    output logic [1:0]         cause,
    output logic [STATE_W-1:0] state_o
);
    import mips_ctrl_pkg::*;

    logic [ST_W-1:0] state_q;
    logic [ST_W-1:0] state_d;
    logic            timeout;
    logic            wait_active;

    assign wait_active = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) ||
                         (state_q == ST_MEM_WR);

`ifdef MC_CTRL_EXC_EN
    logic [1:0] cause_q;
    logic [1:0] cause_d;

    mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .active    (wait_active),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    assign cause = reset ? CAUSE_NONE : cause_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{MEM_TIMEOUT, wait_active};
    assign timeout    = 1'b0;
    assign cause      = CAUSE_NONE;
`endif

    // Outputs are forced low during reset so no strobe of an aborted
    // instruction reaches the datapath in the reset cycle.
    assign state_o = reset ? '0 : STATE_W'(state_q);

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = M2R_ALUOUT;
        reg_dst       = RDST_RT;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        alu_op        = ALU_ADD;
        pc_source     = PCS_ALU;
        epc_write     = 1'b0;
`ifdef MC_CTRL_EXC_EN
        cause_d       = cause_q;
`endif
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    // PC+4 computed while the instruction is read
                    mem_read  = !timeout;
                    alu_src_b = SRCB_FOUR;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = ST_DECODE;
                    end else if (timeout) begin
                        state_d = ST_EXCEPT;
`ifdef MC_CTRL_EXC_EN
                        cause_d = CAUSE_TIMEOUT;
`endif
                    end
                end
                ST_DECODE: begin
                    // speculative branch target into ALUOut
                    alu_src_b = SRCB_IMM_SH;
                    if (opcode == OP_RTYPE) begin
                        state_d = (funct == FUNCT_JR) ? ST_JR : ST_R_EXEC;
                    end else if (is_load(opcode) || is_store(opcode)) begin
                        state_d = ST_MEM_ADDR;
                    end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
                        state_d = ST_BRANCH;
                    end else if (opcode == OP_J || opcode == OP_JAL) begin
                        state_d = ST_JUMP;
                    end else if (is_itype(opcode)) begin
                        state_d = ST_I_EXEC;
                    end else begin
`ifdef MC_CTRL_EXC_EN
                        state_d = ST_EXCEPT;
                        cause_d = CAUSE_ILLEGAL;
`else
                        state_d = ST_FETCH;
`endif
                    end
                end
                ST_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    state_d   = is_load(opcode) ? ST_MEM_RD : ST_MEM_WR;
                end
                ST_MEM_RD: begin
                    mem_read = !timeout;
                    iord     = 1'b1;
                    if (mem_ready)    state_d = ST_MEM_WB;
                    else if (timeout) begin
                        state_d = ST_EXCEPT;
`ifdef MC_CTRL_EXC_EN
                        cause_d = CAUSE_TIMEOUT;
`endif
                    end
                end
                ST_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = M2R_MDR;
                    state_d    = ST_FETCH;
                end
                ST_MEM_WR: begin
                    mem_write = !timeout;
                    iord      = 1'b1;
                    if (mem_ready)    state_d = ST_FETCH;
                    else if (timeout) begin
                        state_d = ST_EXCEPT;
`ifdef MC_CTRL_EXC_EN
                        cause_d = CAUSE_TIMEOUT;
`endif
                    end
                end
                ST_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_RFUNCT;
                    state_d   = ST_R_WB;
                end
                ST_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = RDST_RD;
                    state_d   = ST_FETCH;
                end
                ST_I_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALU_IOP;
                    state_d   = ST_I_WB;
                end
                ST_I_WB: begin
                    reg_write = 1'b1;
                    state_d   = ST_FETCH;
                end
                ST_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PCS_ALUOUT;
                    branch_ne     = (opcode == OP_BNE);
                    state_d       = ST_FETCH;
                end
                ST_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = PCS_JUMP;
                    // PC already holds PC+4, so it is the link value
                    if (opcode == OP_JAL) begin
                        reg_write  = 1'b1;
                        reg_dst    = RDST_RA;
                        mem_to_reg = M2R_PC;
                    end
                    state_d = ST_FETCH;
                end
                ST_JR: begin
                    pc_write  = 1'b1;
                    pc_source = PCS_REG_A;
                    state_d   = ST_FETCH;
                end
`ifdef MC_CTRL_EXC_EN
                ST_EXCEPT: begin
                    // vector is PC+4 through the ALU path
                    epc_write = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    pc_source = PCS_ALU;
                    state_d   = ST_FETCH;
                end
`endif
                default: state_d = ST_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
`ifdef MC_CTRL_EXC_EN
            cause_q <= CAUSE_NONE;
`endif
        end else begin
            state_q <= state_d;
`ifdef MC_CTRL_EXC_EN
            cause_q <= cause_d;
`endif
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm with an expectation queue.
// Latency: one expectation per clock, compared on the falling edge.
// Backpressure: mem_ready is driven per step to create wait cycles.
module tb_multicycle_control_fsm;

    localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1, S_MADDR = 4'd2,
                           S_MRD   = 4'd3,  S_MWB    = 4'd4, S_MWR   = 4'd5,
                           S_REX   = 4'd6,  S_RWB    = 4'd7, S_IEX   = 4'd8,
                           S_IWB   = 4'd9,  S_BR     = 4'd10, S_J    = 4'd11,
                           S_JR    = 4'd12, S_EXC    = 4'd13;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       mem_ready = 1'b1;
    logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write;
    logic [1:0] mem_to_reg, reg_dst, alu_src_b, alu_op, pc_source, cause;
    logic       reg_write, alu_src_a, epc_write;
    logic [3:0] state_o;

    multicycle_control_fsm #(.MEM_TIMEOUT(16), .STATE_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .epc_write(epc_write), .cause(cause), .state_o(state_o)
    );

    always #5 clk = ~clk;

    logic [25:0] obs_vec;
    assign obs_vec = {state_o, pc_write, pc_write_cond, branch_ne, iord, mem_read,
                      mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                      alu_src_b, alu_op, pc_source, epc_write, cause};

    typedef struct {
        string       tag;
        logic [25:0] vec;
    } exp_t;

    exp_t       sb_q[$];
    int         n_chk = 0;
    int         n_fail = 0;
    logic [1:0] exp_cause = 2'b00;

    // Expected outputs per state, written from the controller's output table.
    // `to` marks the cycle where the memory wait times out.
    function automatic logic [25:0] expect_out(input logic [3:0] st, input logic [5:0] op,
                                               input logic mr, input logic rst,
                                               input logic to, input logic [1:0] cz);
        logic       pcw = 0, pcc = 0, bne = 0, ad = 0, mrd = 0, mwr = 0, irw = 0;
        logic       rw = 0, sa = 0, epc = 0;
        logic [1:0] m2r = 0, rd = 0, sb = 0, aop = 0, ps = 0;
        if (rst) return '0;
        case (st)
            S_FETCH:  begin mrd = !to; sb = 2'b01; if (mr) begin irw = 1; pcw = 1; end end
            S_DECODE: sb = 2'b11;
            S_MADDR:  begin sa = 1; sb = 2'b10; end
            S_MRD:    begin mrd = !to; ad = 1; end
            S_MWB:    begin rw = 1; m2r = 2'b01; end
            S_MWR:    begin mwr = !to; ad = 1; end
            S_REX:    begin sa = 1; aop = 2'b10; end
            S_RWB:    begin rw = 1; rd = 2'b01; end
            S_IEX:    begin sa = 1; sb = 2'b10; aop = 2'b11; end
            S_IWB:    rw = 1;
            S_BR:     begin sa = 1; aop = 2'b01; pcc = 1; ps = 2'b01; bne = (op == 6'd5); end
            S_J:      begin
                          pcw = 1; ps = 2'b10;
                          if (op == 6'd3) begin rw = 1; rd = 2'b10; m2r = 2'b10; end
                      end
            S_JR:     begin pcw = 1; ps = 2'b11; end
            S_EXC:    begin epc = 1; pcw = 1; sb = 2'b01; end
            default:  ;
        endcase
        return {st, pcw, pcc, bne, ad, mrd, mwr, irw, m2r, rd, rw, sa, sb, aop, ps, epc, cz};
    endfunction

    task automatic step(input string tag, input logic rst, input logic mr,
                        input logic [5:0] op, input logic [5:0] fn,
                        input logic [3:0] st, input logic to);
        exp_t e;
        reset     = rst;
        mem_ready = mr;
        opcode    = op;
        funct     = fn;
        e.tag = tag;
        e.vec = expect_out(st, op, mr, rst, to, exp_cause);
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        n_chk++;
        assert (obs_vec === e.vec) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", e.tag, obs_vec, e.vec);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with mem_ready high: everything low
        for (int i = 0; i < 3; i++) step("reset", 1, 1, 6'd0, 6'd0, S_FETCH, 0);

        // lw with two wait cycles in MEM_RD
        step("lw_fetch",  0, 1, 6'd35, 6'd0, S_FETCH,  0);
        step("lw_decode", 0, 1, 6'd35, 6'd0, S_DECODE, 0);
        step("lw_addr",   0, 0, 6'd35, 6'd0, S_MADDR,  0);
        step("lw_wait1",  0, 0, 6'd35, 6'd0, S_MRD,    0);
        step("lw_wait2",  0, 0, 6'd35, 6'd0, S_MRD,    0);
        step("lw_rd",     0, 1, 6'd35, 6'd0, S_MRD,    0);
        step("lw_wb",     0, 0, 6'd35, 6'd0, S_MWB,    0);

        // bne then beq
        step("bne_fetch",  0, 1, 6'd5, 6'd0, S_FETCH,  0);
        step("bne_decode", 0, 1, 6'd5, 6'd0, S_DECODE, 0);
        step("bne_branch", 0, 1, 6'd5, 6'd0, S_BR,     0);
        step("beq_fetch",  0, 1, 6'd4, 6'd0, S_FETCH,  0);
        step("beq_decode", 0, 1, 6'd4, 6'd0, S_DECODE, 0);
        step("beq_branch", 0, 1, 6'd4, 6'd0, S_BR,     0);

        // jal, j, jr
        step("jal_fetch",  0, 1, 6'd3, 6'd0, S_FETCH,  0);
        step("jal_decode", 0, 1, 6'd3, 6'd0, S_DECODE, 0);
        step("jal_jump",   0, 1, 6'd3, 6'd0, S_J,      0);
        step("j_fetch",    0, 1, 6'd2, 6'd0, S_FETCH,  0);
        step("j_decode",   0, 1, 6'd2, 6'd0, S_DECODE, 0);
        step("j_jump",     0, 1, 6'd2, 6'd0, S_J,      0);
        step("jr_fetch",   0, 1, 6'd0, 6'h08, S_FETCH, 0);
        step("jr_decode",  0, 1, 6'd0, 6'h08, S_DECODE, 0);
        step("jr_exec",    0, 1, 6'd0, 6'h08, S_JR,    0);

        // R-type add and addi
        step("r_fetch",    0, 1, 6'd0, 6'h20, S_FETCH,  0);
        step("r_decode",   0, 1, 6'd0, 6'h20, S_DECODE, 0);
        step("r_exec",     0, 1, 6'd0, 6'h20, S_REX,    0);
        step("r_wb",       0, 1, 6'd0, 6'h20, S_RWB,    0);
        step("i_fetch",    0, 1, 6'd8, 6'd0, S_FETCH,  0);
        step("i_decode",   0, 1, 6'd8, 6'd0, S_DECODE, 0);
        step("i_exec",     0, 1, 6'd8, 6'd0, S_IEX,    0);
        step("i_wb",       0, 1, 6'd8, 6'd0, S_IWB,    0);

        // sw with one wait cycle in MEM_WR
        step("sw_fetch",   0, 1, 6'd43, 6'd0, S_FETCH,  0);
        step("sw_decode",  0, 1, 6'd43, 6'd0, S_DECODE, 0);
        step("sw_addr",    0, 1, 6'd43, 6'd0, S_MADDR,  0);
        step("sw_wait",    0, 0, 6'd43, 6'd0, S_MWR,    0);
        step("sw_wr",      0, 1, 6'd43, 6'd0, S_MWR,    0);

        // illegal opcode
        step("ill_fetch",  0, 1, 6'd63, 6'd0, S_FETCH,  0);
        step("ill_decode", 0, 1, 6'd63, 6'd0, S_DECODE, 0);
`ifdef MC_CTRL_EXC_EN
        exp_cause = 2'b01;
        step("ill_except", 0, 1, 6'd63, 6'd0, S_EXC,    0);

        // fetch never completes: 16th wait cycle times out
        for (int i = 1; i <= 16; i++) begin
            step((i == 16) ? "to_last_wait" : "to_wait", 0, 0, 6'd0, 6'd0, S_FETCH, (i == 16));
        end
        exp_cause = 2'b10;
        step("to_except",  0, 0, 6'd0, 6'd0, S_EXC, 0);
`endif

        // reset in the middle of a store
        step("rsw_fetch",  0, 1, 6'd43, 6'd0, S_FETCH,  0);
        step("rsw_decode", 0, 1, 6'd43, 6'd0, S_DECODE, 0);
        step("rsw_addr",   0, 0, 6'd43, 6'd0, S_MADDR,  0);
        step("rsw_reset",  1, 0, 6'd43, 6'd0, S_MWR,    0);
        exp_cause = 2'b00;
        step("rsw_after",  0, 0, 6'd43, 6'd0, S_FETCH,  0);
        step("rsw_resume", 0, 1, 6'd43, 6'd0, S_FETCH,  0);
        step("rsw_decode2", 0, 1, 6'd43, 6'd0, S_DECODE, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
